// File: rtl/arbitro_ula_if.sv
// Bus bundle between the ULA arbiter, its requesting clients and the shared ULA.
//   Client side : req, op_req, a_req, b_req (to arbiter); ack, erro, resultado,
//                 grant_id, ocupado (from arbiter).
//   ULA side    : ula_processar, ula_op, ula_etp1, ula_etp2 (from arbiter);
//                 ula_concluido, ula_data (to arbiter).
// Modports:
//   slave  - the arbiter's view.
//   master - the environment's view (clients plus the ULA).
interface arbitro_ula_if #(
  parameter int Tamanho_Da_Palavra = 16,
  parameter int NUM_REQ            = 4
);
  localparam int W    = Tamanho_Da_Palavra;
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] op_req;
  logic [W*NUM_REQ-1:0] a_req;
  logic [W*NUM_REQ-1:0] b_req;
  logic [NUM_REQ-1:0]   ack;
  logic                 erro;
  logic [W-1:0]         resultado;
  logic [ID_W-1:0]      grant_id;
  logic                 ocupado;

  logic                 ula_processar;
  logic [3:0]           ula_op;
  logic [W-1:0]         ula_etp1;
  logic [W-1:0]         ula_etp2;
  logic                 ula_concluido;
  logic [W-1:0]         ula_data;

  modport slave (
    input  req, op_req, a_req, b_req, ula_concluido, ula_data,
    output ack, erro, resultado, grant_id, ocupado,
           ula_processar, ula_op, ula_etp1, ula_etp2
  );

  modport master (
    output req, op_req, a_req, b_req, ula_concluido, ula_data,
    input  ack, erro, resultado, grant_id, ocupado,
           ula_processar, ula_op, ula_etp1, ula_etp2
  );
endinterface

// File: rtl/arbitro_ula.sv
// Round-robin arbiter/sequencer sharing one ULA among NUM_REQ clients.
// A winner's op/operands are latched, the ULA receives a one-cycle start pulse,
// the result is returned to the winner with a one-cycle ack, and the arbiter
// waits for the ULA done flag to fall before accepting the next request.
// Ports:
//   clk   - single clock, posedge.
//   reset - asynchronous, active-low.
//   bus   - arbitro_ula_if.slave (client requests/acks and ULA handshake).
// Optional feature: define ARBITRO_TIMEOUT_EN to enable a watchdog that aborts
// a ULA operation after TIMEOUT cycles (erro=1) and bounds the drain wait.
// Every output is driven directly from a flop, so outputs change one cycle
// after the state that produces them (start pulse seen during the first
// AGUARDA cycle, ack seen during the cycle after ENTREGA).
module arbitro_ula #(
  parameter int Tamanho_Da_Palavra = 16,
  parameter int NUM_REQ            = 4,
  parameter int TIMEOUT            = 31
) (
  input  logic         clk,
  input  logic         reset,
  arbitro_ula_if.slave bus
);
  localparam int W    = Tamanho_Da_Palavra;
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW   = ID_W + 1;
  localparam logic [3:0] OP_MAX = 4'd9;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    EMITE   = 3'd1,
    AGUARDA = 3'd2,
    ENTREGA = 3'd3,
    DRENO   = 3'd4
  } estado_t;

  estado_t              state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [3:0]           op_q, op_d;
  logic [W-1:0]         etp1_q, etp1_d;
  logic [W-1:0]         etp2_q, etp2_d;
  logic                 processar_q, processar_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 erro_q, erro_d;
  logic [W-1:0]         resultado_q, resultado_d;
  logic                 ocupado_q, ocupado_d;
  logic [W-1:0]         cap_dado_q, cap_dado_d;
  logic                 cap_erro_q, cap_erro_d;
  logic                 iniciou_q, iniciou_d;

`ifdef ARBITRO_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
`else
  logic                 unused_tmo_s;
  assign unused_tmo_s = (TIMEOUT > 32'sd0);
`endif

  // Unpack the client buses into per-client arrays (constant slices only).
  logic [3:0]   op_arr_s [NUM_REQ];
  logic [W-1:0] a_arr_s  [NUM_REQ];
  logic [W-1:0] b_arr_s  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr_s[g] = bus.op_req[4*g +: 4];
    assign a_arr_s[g]  = bus.a_req[W*g +: W];
    assign b_arr_s[g]  = bus.b_req[W*g +: W];
  end

  // Round-robin search: first requesting client at or after the pointer, wrapping.
  logic [NUM_REQ-1:0] req_m_s;
  logic               found_s;
  logic [ID_W-1:0]    win_s;
  logic [SW-1:0]      sum_s;
  logic [SW-1:0]      cand_s;

  always_comb begin
    // A client whose ack is on the bus this cycle is masked so a req still
    // held during its own ack is not taken as a fresh request.
    req_m_s = bus.req & ~ack_q;
    found_s = 1'b0;
    win_s   = '0;
    sum_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s  = {1'b0, ptr_q} + SW'(k);
      cand_s = (sum_s >= SW'(NUM_REQ)) ? (sum_s - SW'(NUM_REQ)) : sum_s;
      if (!found_s && req_m_s[cand_s[ID_W-1:0]]) begin
        found_s = 1'b1;
        win_s   = cand_s[ID_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer value after serving the current client.
  logic [ID_W-1:0] ptr_nxt_s;
  assign ptr_nxt_s = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : (grant_q + ID_W'(1));

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    op_d        = op_q;
    etp1_d      = etp1_q;
    etp2_d      = etp2_q;
    processar_d = 1'b0;
    ack_d       = '0;
    erro_d      = 1'b0;
    resultado_d = resultado_q;
    cap_dado_d  = cap_dado_q;
    cap_erro_d  = cap_erro_q;
    iniciou_d   = iniciou_q;
`ifdef ARBITRO_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      OCIOSO: begin
        if (found_s) begin
          grant_d = win_s;
          op_d    = op_arr_s[win_s];
          etp1_d  = a_arr_s[win_s];
          etp2_d  = b_arr_s[win_s];
          if (op_arr_s[win_s] > OP_MAX) begin
            // Unsupported op: answer with an error, never start the ULA.
            cap_erro_d = 1'b1;
            cap_dado_d = '0;
            iniciou_d  = 1'b0;
            state_d    = ENTREGA;
          end else begin
            cap_erro_d = 1'b0;
            iniciou_d  = 1'b1;
            state_d    = EMITE;
          end
        end else begin
          state_d = OCIOSO;
        end
      end

      EMITE: begin
        processar_d = 1'b1;
        state_d     = AGUARDA;
`ifdef ARBITRO_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end

      AGUARDA: begin
        // While the start pulse is still on the wire the ULA cannot have
        // answered it yet, so a done level seen then is ignored.
        if (bus.ula_concluido && !processar_q) begin
          cap_dado_d = bus.ula_data;
          cap_erro_d = 1'b0;
          state_d    = ENTREGA;
`ifdef ARBITRO_TIMEOUT_EN
        end else if (cnt_q >= CNT_LIM) begin
          cap_dado_d = '0;
          cap_erro_d = 1'b1;
          state_d    = ENTREGA;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
        end
`else
        end else begin
          state_d    = AGUARDA;
        end
`endif
      end

      ENTREGA: begin
        ack_d       = NUM_REQ'(1) << grant_q;
        erro_d      = cap_erro_q;
        resultado_d = cap_dado_q;
        ptr_d       = ptr_nxt_s;
        if (iniciou_q) begin
          state_d = DRENO;
`ifdef ARBITRO_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = OCIOSO;
        end
      end

      DRENO: begin
        if (!bus.ula_concluido) begin
          state_d = OCIOSO;
`ifdef ARBITRO_TIMEOUT_EN
        end else if (cnt_q >= CNT_LIM) begin
          state_d = OCIOSO;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`else
        end else begin
          state_d = DRENO;
        end
`endif
      end

      default: begin
        state_d = OCIOSO;
      end
    endcase

    ocupado_d = (state_d != OCIOSO);
  end

  // State and output registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= OCIOSO;
      ptr_q       <= '0;
      grant_q     <= '0;
      op_q        <= 4'd0;
      etp1_q      <= '0;
      etp2_q      <= '0;
      processar_q <= 1'b0;
      ack_q       <= '0;
      erro_q      <= 1'b0;
      resultado_q <= '0;
      ocupado_q   <= 1'b0;
      cap_dado_q  <= '0;
      cap_erro_q  <= 1'b0;
      iniciou_q   <= 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      op_q        <= op_d;
      etp1_q      <= etp1_d;
      etp2_q      <= etp2_d;
      processar_q <= processar_d;
      ack_q       <= ack_d;
      erro_q      <= erro_d;
      resultado_q <= resultado_d;
      ocupado_q   <= ocupado_d;
      cap_dado_q  <= cap_dado_d;
      cap_erro_q  <= cap_erro_d;
      iniciou_q   <= iniciou_d;
`ifdef ARBITRO_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.ack           = ack_q;
  assign bus.erro          = erro_q;
  assign bus.resultado     = resultado_q;
  assign bus.grant_id      = grant_q;
  assign bus.ocupado       = ocupado_q;
  assign bus.ula_processar = processar_q;
  assign bus.ula_op        = op_q;
  assign bus.ula_etp1      = etp1_q;
  assign bus.ula_etp2      = etp2_q;

endmodule

// File: tb/tb_arbitro_ula.sv
// Directed self-checking bench for arbitro_ula (W=16, NUM_REQ=4, TIMEOUT=31).
// A small ULA responder raises ula_concluido a configurable number of cycles
// after each start pulse and holds it for a configurable number of cycles.
module tb_arbitro_ula;
  localparam int W   = 16;
  localparam int N   = 4;
  localparam int TMO = 31;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  int   cyc;

  arbitro_ula_if #(.Tamanho_Da_Palavra(W), .NUM_REQ(N)) bus ();

  arbitro_ula #(.Tamanho_Da_Palavra(W), .NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ULA responder
  int ula_lat;
  int ula_hold;
  bit ula_mudo;
  int ula_cnt;
  int ula_hold_cnt;

  function automatic logic [W-1:0] ula_f(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      default: return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      ula_cnt           <= 0;
      ula_hold_cnt      <= 0;
      bus.ula_concluido <= 1'b0;
      bus.ula_data      <= 16'd0;
    end else if (bus.ula_processar && !ula_mudo) begin
      ula_cnt <= ula_lat;
    end else if (ula_cnt > 1) begin
      ula_cnt <= ula_cnt - 1;
    end else if (ula_cnt == 1) begin
      ula_cnt           <= 0;
      bus.ula_concluido <= 1'b1;
      bus.ula_data      <= ula_f(bus.ula_op, bus.ula_etp1, bus.ula_etp2);
      ula_hold_cnt      <= ula_hold;
    end else if (ula_hold_cnt > 1) begin
      ula_hold_cnt <= ula_hold_cnt - 1;
    end else if (ula_hold_cnt == 1) begin
      ula_hold_cnt      <= 0;
      bus.ula_concluido <= 1'b0;
    end
  end

  // Handshake monitor
  int   proc_cnt;
  int   viol_cnt;
  int   last_proc_cyc;
  int   last_conc_cyc;
  logic conc_prev;

  always @(negedge clk) begin
    if (bus.ula_processar === 1'b1) begin
      proc_cnt      = proc_cnt + 1;
      last_proc_cyc = cyc;
      if (bus.ula_concluido === 1'b1) viol_cnt = viol_cnt + 1;
    end
    if (bus.ula_concluido === 1'b1 && conc_prev !== 1'b1) last_conc_cyc = cyc;
    conc_prev = bus.ula_concluido;
  end

  task automatic set_client(input int i, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
    bus.op_req[4*i +: 4] = op;
    bus.a_req[W*i +: W]  = a;
    bus.b_req[W*i +: W]  = b;
  endtask

  task automatic wait_ack(input int budget, output bit got, output int at_cyc);
    got    = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.ack !== 4'b0000) begin
        got    = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus.ocupado !== 1'b0 || bus.ack !== 4'b0000 || bus.ula_processar !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ocupado=%b ack=%b processar=%b, required 0/0000/0",
               bus.ocupado, bus.ack, bus.ula_processar);
    end
    tests_run++;
    if (bus.resultado !== 16'd0 || bus.erro !== 1'b0 || bus.grant_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_data: resultado=%h erro=%b grant_id=%0d, required 0/0/0",
               bus.resultado, bus.erro, bus.grant_id);
    end
  endtask

  task automatic test_single();
    bit got; int ack_cyc; int c0; int p0;
    p0 = proc_cnt;
    set_client(0, 4'd0, 16'd7, 16'd5);
    bus.req = 4'b0001;
    c0 = cyc;
    wait_ack(40, got, ack_cyc);
    tests_run++;
    if (!got || bus.ack !== 4'b0001 || bus.erro !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_ack: got=%0d ack=%b erro=%b, required 1/0001/0", got, bus.ack, bus.erro);
    end
    tests_run++;
    if (bus.resultado !== 16'd12) begin
      tests_failed++;
      $display("FAIL single_result: resultado=%0d, required 12", bus.resultado);
    end
    bus.req = 4'b0000;
    tests_run++;
    if (last_proc_cyc - c0 !== 2) begin
      tests_failed++;
      $display("FAIL req_to_processar: latency=%0d, required 2", last_proc_cyc - c0);
    end
    tests_run++;
    if (ack_cyc - last_conc_cyc !== 2) begin
      tests_failed++;
      $display("FAIL concluido_to_ack: latency=%0d, required 2", ack_cyc - last_conc_cyc);
    end
    repeat (6) @(negedge clk);
    tests_run++;
    if (proc_cnt - p0 !== 1) begin
      tests_failed++;
      $display("FAIL single_pulses: processar pulses=%0d, required 1", proc_cnt - p0);
    end
  endtask

  task automatic test_round_robin();
    bit got; int ack_cyc;
    int ids [5];
    logic [3:0] exp_ack;
    ids = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) set_client(i, 4'd1, 16'd20, 16'd3);
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_ack(40, got, ack_cyc);
      exp_ack = 4'b0001 << ids[t];
      tests_run++;
      if (!got || bus.ack !== exp_ack) begin
        tests_failed++;
        $display("FAIL rr_ack[%0d]: got=%0d ack=%b, required %b", t, got, bus.ack, exp_ack);
      end
      tests_run++;
      if (bus.grant_id !== 2'(ids[t])) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d]: grant_id=%0d, required %0d", t, bus.grant_id, ids[t]);
      end
      tests_run++;
      if (bus.resultado !== 16'd17 || bus.erro !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_result[%0d]: resultado=%0d erro=%b, required 17/0",
                 t, bus.resultado, bus.erro);
      end
    end
    bus.req = 4'b0000;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_invalid_op();
    bit got; int ack_cyc; int c0; int p0;
    p0 = proc_cnt;
    set_client(2, 4'hC, 16'd1, 16'd2);
    bus.req = 4'b0100;
    c0 = cyc;
    @(negedge clk);
    tests_run++;
    if (bus.resultado !== 16'd17) begin
      tests_failed++;
      $display("FAIL result_hold: resultado=%0d, required 17", bus.resultado);
    end
    wait_ack(10, got, ack_cyc);
    tests_run++;
    if (!got || bus.ack !== 4'b0100 || ack_cyc - c0 > 2) begin
      tests_failed++;
      $display("FAIL bad_op_ack: got=%0d ack=%b latency=%0d, required 1/0100/<=2",
               got, bus.ack, ack_cyc - c0);
    end
    tests_run++;
    if (bus.erro !== 1'b1 || bus.resultado !== 16'd0) begin
      tests_failed++;
      $display("FAIL bad_op_err: erro=%b resultado=%0d, required 1/0", bus.erro, bus.resultado);
    end
    bus.req = 4'b0000;
    repeat (6) @(negedge clk);
    tests_run++;
    if (proc_cnt - p0 !== 0) begin
      tests_failed++;
      $display("FAIL bad_op_nostart: processar pulses=%0d, required 0", proc_cnt - p0);
    end
  endtask

  task automatic test_back_to_back();
    bit got; int ack_cyc; int p0; int v0;
    p0 = proc_cnt;
    v0 = viol_cnt;
    ula_hold = 6;
    set_client(1, 4'd2, 16'd300, 16'd200);
    bus.req = 4'b0010;
    for (int t = 0; t < 2; t++) begin
      wait_ack(60, got, ack_cyc);
      tests_run++;
      if (!got || bus.ack !== 4'b0010 || bus.resultado !== 16'hEA60 || bus.erro !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_ack[%0d]: got=%0d ack=%b resultado=%h erro=%b, required 1/0010/ea60/0",
                 t, got, bus.ack, bus.resultado, bus.erro);
      end
      tests_run++;
      if (bus.ula_op !== 4'd2 || bus.ula_etp1 !== 16'd300 || bus.ula_etp2 !== 16'd200) begin
        tests_failed++;
        $display("FAIL b2b_operands[%0d]: op=%0d etp1=%0d etp2=%0d, required 2/300/200",
                 t, bus.ula_op, bus.ula_etp1, bus.ula_etp2);
      end
    end
    bus.req = 4'b0000;
    repeat (12) @(negedge clk);
    tests_run++;
    if (viol_cnt - v0 !== 0 || proc_cnt - p0 !== 2) begin
      tests_failed++;
      $display("FAIL b2b_drain: starts_while_busy=%0d pulses=%0d, required 0/2",
               viol_cnt - v0, proc_cnt - p0);
    end
    ula_hold = 2;
  endtask

  task automatic test_reset_mid();
    bit got; int ack_cyc;
    ula_mudo = 1'b1;
    set_client(3, 4'd0, 16'd1, 16'd1);
    bus.req = 4'b1000;
    repeat (5) @(negedge clk);
    tests_run++;
    if (bus.ocupado !== 1'b1 || bus.grant_id !== 2'd3) begin
      tests_failed++;
      $display("FAIL mid_busy: ocupado=%b grant_id=%0d, required 1/3", bus.ocupado, bus.grant_id);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.ocupado !== 1'b0 || bus.ack !== 4'b0000 || bus.resultado !== 16'd0 ||
        bus.grant_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: ocupado=%b ack=%b resultado=%h grant_id=%0d, required 0/0000/0/0",
               bus.ocupado, bus.ack, bus.resultado, bus.grant_id);
    end
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    ula_mudo = 1'b0;
    @(negedge clk);
    set_client(0, 4'd0, 16'd2, 16'd3);
    bus.req = 4'b1001;
    wait_ack(40, got, ack_cyc);
    tests_run++;
    if (!got || bus.ack !== 4'b0001 || bus.resultado !== 16'd5) begin
      tests_failed++;
      $display("FAIL post_reset_first: got=%0d ack=%b resultado=%0d, required 1/0001/5",
               got, bus.ack, bus.resultado);
    end
    bus.req = 4'b1000;
    wait_ack(40, got, ack_cyc);
    tests_run++;
    if (!got || bus.ack !== 4'b1000 || bus.resultado !== 16'd2) begin
      tests_failed++;
      $display("FAIL post_reset_second: got=%0d ack=%b resultado=%0d, required 1/1000/2",
               got, bus.ack, bus.resultado);
    end
    bus.req = 4'b0000;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit got; int ack_cyc;
    ula_mudo = 1'b1;
    set_client(0, 4'd0, 16'd9, 16'd9);
    bus.req = 4'b0001;
`ifdef ARBITRO_TIMEOUT_EN
    wait_ack(80, got, ack_cyc);
    bus.req = 4'b0000;
    tests_run++;
    if (!got || bus.ack !== 4'b0001 || bus.erro !== 1'b1 || bus.resultado !== 16'd0) begin
      tests_failed++;
      $display("FAIL timeout_ack: got=%0d ack=%b erro=%b resultado=%h, required 1/0001/1/0",
               got, bus.ack, bus.erro, bus.resultado);
    end
    tests_run++;
    if (ack_cyc - last_proc_cyc !== TMO + 1) begin
      tests_failed++;
      $display("FAIL timeout_latency: cycles=%0d, required %0d", ack_cyc - last_proc_cyc, TMO + 1);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (bus.ocupado !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_idle: ocupado=%b, required 0", bus.ocupado);
    end
`else
    wait_ack(60, got, ack_cyc);
    tests_run++;
    if (got || bus.ocupado !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_forever: got_ack=%0d ocupado=%b, required 0/1", got, bus.ocupado);
    end
    bus.req = 4'b0000;
    do_reset();
`endif
    ula_mudo = 1'b0;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    cyc           = 0;
    proc_cnt      = 0;
    viol_cnt      = 0;
    last_proc_cyc = 0;
    last_conc_cyc = 0;
    conc_prev     = 1'b0;
    ula_lat       = 2;
    ula_hold      = 2;
    ula_mudo      = 1'b0;
    reset         = 1'b0;
    bus.req       = 4'b0000;
    bus.op_req    = 16'd0;
    bus.a_req     = 64'd0;
    bus.b_req     = 64'd0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_single();
    test_round_robin();
    test_invalid_op();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "time limit");
  end

endmodule
